// File: rtl/bsg_lru_pseudo_tree_state_if.sv
// Update/read bus between a cache controller (master) and the per-set
// pseudo-LRU tree storage (slave).
interface bsg_lru_pseudo_tree_state_if #(
  parameter int ways_p = 16,
  parameter int sets_p = 64
);
  localparam int lg_ways_lp = $clog2(ways_p);
  localparam int lg_sets_lp = $clog2(sets_p);

  logic                  ready_o;
  logic                  w_v_i;
  logic [lg_sets_lp-1:0] w_set_i;
  logic [ways_p-2:0]     w_data_i;
  logic [ways_p-2:0]     w_mask_i;
  logic                  r_v_i;
  logic [lg_sets_lp-1:0] r_set_i;
  logic                  lru_v_o;
  logic [lg_ways_lp-1:0] lru_way_o;

  modport master (
    input  ready_o, lru_v_o, lru_way_o,
    output w_v_i, w_set_i, w_data_i, w_mask_i, r_v_i, r_set_i
  );

  modport slave (
    output ready_o, lru_v_o, lru_way_o,
    input  w_v_i, w_set_i, w_data_i, w_mask_i, r_v_i, r_set_i
  );
endinterface

// File: rtl/bsg_lru_pseudo_tree_state.sv
// Per-set pseudo-LRU tree bits with masked updates, a registered LRU-way read
// port and a post-reset clearing sweep. Optional err_o via BSG_LRU_TREE_STATE_ERR_EN.
module bsg_lru_pseudo_tree_state #(
  parameter int ways_p = 16,
  parameter int sets_p = 64
) (
  input  logic clk_i,
  input  logic reset_n_i,
  bsg_lru_pseudo_tree_state_if.slave bus_if
`ifdef BSG_LRU_TREE_STATE_ERR_EN
  , output logic err_o
`endif
);
  localparam int lg_ways_lp = $clog2(ways_p);
  localparam int lg_sets_lp = $clog2(sets_p);

  typedef enum logic {INIT, READY} state_e;

  state_e                state_q, state_d;
  logic [lg_sets_lp-1:0] cnt_q, cnt_d;
  logic [ways_p-2:0]     rows_q [sets_p];

  logic                  ready;
  logic                  w_set_ok, r_set_ok;
  logic                  wr_en;
  logic [lg_sets_lp-1:0] wr_idx;
  logic [ways_p-2:0]     wr_row;
  logic [ways_p-2:0]     rd_row;

  logic                  lru_v_q, lru_v_d;
  logic [lg_ways_lp-1:0] lru_way_q, lru_way_d;

  // Node bit 1 means the MRU side is the left subtree, so the walk goes right.
  function automatic logic [lg_ways_lp-1:0] encode(input logic [ways_p-2:0] row);
    logic [lg_ways_lp-1:0] way;
    int n;
    logic b;
    way = '0;
    n   = 0;
    for (int l = lg_ways_lp-1; l >= 0; l--) begin
      b      = row[n];
      way[l] = b;
      n      = b ? (2*n + 2) : (2*n + 1);
    end
    return way;
  endfunction

  generate
    if (sets_p == (1 << lg_sets_lp)) begin : g_pow2
      assign w_set_ok = 1'b1;
      assign r_set_ok = 1'b1;
    end else begin : g_npow2
      assign w_set_ok = (32'(bus_if.w_set_i) < sets_p);
      assign r_set_ok = (32'(bus_if.r_set_i) < sets_p);
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == lg_sets_lp'(sets_p-1)) begin
        state_d = READY;
      end
    end
  end

  always_comb begin
    ready = (state_q == READY);
  end

  assign bus_if.ready_o = ready;

  // Single write port, shared by the clearing sweep and by masked updates.
  always_comb begin
    wr_en  = 1'b0;
    wr_idx = cnt_q;
    wr_row = '0;
    if (!ready) begin
      wr_en = 1'b1;
    end else if (bus_if.w_v_i && w_set_ok) begin
      wr_en  = 1'b1;
      wr_idx = bus_if.w_set_i;
      wr_row = (rows_q[bus_if.w_set_i] & ~bus_if.w_mask_i)
             | (bus_if.w_data_i & bus_if.w_mask_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      rows_q[wr_idx] <= wr_row;
    end
  end

  always_comb begin
    rd_row = rows_q[bus_if.r_set_i];
    if (wr_en && (wr_idx == bus_if.r_set_i)) begin
      rd_row = wr_row;
    end
  end

  always_comb begin
    lru_v_d   = 1'b0;
    lru_way_d = lru_way_q;
    if (ready && bus_if.r_v_i) begin
      lru_v_d   = 1'b1;
      lru_way_d = r_set_ok ? encode(rd_row) : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      lru_v_q   <= 1'b0;
      lru_way_q <= '0;
    end else begin
      lru_v_q   <= lru_v_d;
      lru_way_q <= lru_way_d;
    end
  end

  assign bus_if.lru_v_o   = lru_v_q;
  assign bus_if.lru_way_o = lru_way_q;

`ifdef BSG_LRU_TREE_STATE_ERR_EN
  logic err_q;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_q
             | (!ready && (bus_if.w_v_i || bus_if.r_v_i))
             | (bus_if.w_v_i && !w_set_ok)
             | (bus_if.r_v_i && !r_set_ok);
    end
  end

  assign err_o = err_q;
`endif
endmodule

// File: tb/tb_bsg_lru_pseudo_tree_state.sv
// Directed test of bsg_lru_pseudo_tree_state (ways_p=16, sets_p=64) with
// hand-computed expected LRU ways.
module tb_bsg_lru_pseudo_tree_state;
  localparam int WAYS = 16;
  localparam int SETS = 64;

  logic clk_i = 1'b0;
  logic reset_n_i;
  int   testsRun = 0;
  int   testsFailed = 0;

  bsg_lru_pseudo_tree_state_if #(.ways_p(WAYS), .sets_p(SETS)) bus ();

`ifdef BSG_LRU_TREE_STATE_ERR_EN
  logic err_o;
`endif

  bsg_lru_pseudo_tree_state #(.ways_p(WAYS), .sets_p(SETS)) dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .bus_if    (bus)
`ifdef BSG_LRU_TREE_STATE_ERR_EN
    , .err_o   (err_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Drives one cycle of update/read inputs, then returns them to idle.
  task automatic applyStimulus(input logic wv, input int wset, input logic [15:0] wdata,
                               input logic [15:0] wmask, input logic rv, input int rset);
    bus.w_v_i    = wv;
    bus.w_set_i  = 6'(wset);
    bus.w_data_i = wdata[14:0];
    bus.w_mask_i = wmask[14:0];
    bus.r_v_i    = rv;
    bus.r_set_i  = 6'(rset);
    tick();
    bus.w_v_i    = 1'b0;
    bus.r_v_i    = 1'b0;
  endtask

  task automatic readSet(input string tag, input int rset, input int expWay);
    applyStimulus(1'b0, 0, 16'h0, 16'h0, 1'b1, rset);
    checkOutput({tag, "_v"}, 32'(bus.lru_v_o), 32'd1);
    checkOutput({tag, "_way"}, 32'(bus.lru_way_o), 32'(expWay));
  endtask

  initial begin
    int   n;
    logic sawLruV;

    reset_n_i    = 1'b0;
    bus.w_v_i    = 1'b0;
    bus.w_set_i  = '0;
    bus.w_data_i = '0;
    bus.w_mask_i = '0;
    bus.r_v_i    = 1'b0;
    bus.r_set_i  = '0;
    tick();
    tick();
    checkOutput("rst_ready", 32'(bus.ready_o), 32'd0);
    checkOutput("rst_lru_v", 32'(bus.lru_v_o), 32'd0);
    checkOutput("rst_lru_way", 32'(bus.lru_way_o), 32'd0);
`ifdef BSG_LRU_TREE_STATE_ERR_EN
    checkOutput("rst_err", 32'(err_o), 32'd0);
`endif

    reset_n_i = 1'b1;
    n = 0;
    while (!bus.ready_o && n < 200) begin
      tick();
      n++;
    end
    checkOutput("init_cycles", 32'(n), 32'd64);

    readSet("rd0", 0, 0);
    readSet("rd31", 31, 0);
    readSet("rd63", 63, 0);
    tick();
    checkOutput("idle_lru_v", 32'(bus.lru_v_o), 32'd0);

    applyStimulus(1'b1, 5, 16'h008B, 16'h008B, 1'b0, 0);
    readSet("touch0_s5", 5, 8);
    readSet("untouched_s6", 6, 0);

    applyStimulus(1'b1, 5, 16'h0000, 16'h0825, 1'b0, 0);
    readSet("touch8_s5", 5, 4);
    applyStimulus(1'b1, 5, 16'hFFFF, 16'h0000, 1'b0, 0);
    readSet("zeromask_s5", 5, 4);

    applyStimulus(1'b1, 3, 16'h008B, 16'h008B, 1'b1, 3);
    checkOutput("wfirst_v", 32'(bus.lru_v_o), 32'd1);
    checkOutput("wfirst_way", 32'(bus.lru_way_o), 32'd8);
    tick();
    checkOutput("hold_v", 32'(bus.lru_v_o), 32'd0);
    checkOutput("hold_way", 32'(bus.lru_way_o), 32'd8);

    applyStimulus(1'b1, 12, 16'h008B, 16'h008B, 1'b1, 4);
    checkOutput("indep_s4", 32'(bus.lru_way_o), 32'd0);
    readSet("indep_s12", 12, 8);

    // Restart the sweep part-way through, with traffic held on during INIT.
    reset_n_i = 1'b0;
    tick();
    reset_n_i = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    reset_n_i = 1'b0;
    tick();
    reset_n_i = 1'b1;
    bus.w_v_i    = 1'b1;
    bus.w_set_i  = 6'd5;
    bus.w_data_i = 15'h7FFF;
    bus.w_mask_i = 15'h7FFF;
    bus.r_v_i    = 1'b1;
    bus.r_set_i  = 6'd5;
    sawLruV = 1'b0;
    n = 0;
    while (!bus.ready_o && n < 200) begin
      tick();
      n++;
      sawLruV = sawLruV | bus.lru_v_o;
    end
    bus.w_v_i = 1'b0;
    bus.r_v_i = 1'b0;
    checkOutput("resweep_cycles", 32'(n), 32'd64);
    checkOutput("init_no_lru_v", 32'(sawLruV), 32'd0);
`ifdef BSG_LRU_TREE_STATE_ERR_EN
    checkOutput("err_set", 32'(err_o), 32'd1);
`endif
    readSet("after_s5", 5, 0);
    readSet("after_s3", 3, 0);
    readSet("after_s12", 12, 0);
`ifdef BSG_LRU_TREE_STATE_ERR_EN
    checkOutput("err_sticky", 32'(err_o), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
